// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, handshakes with a variable-latency
// instruction memory and loads the IF/ID registers, with a one-entry hold buffer.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_BOOT  | post-reset idle while memory initialises; no requests, redirects ignored
// ST_FETCH | request outstanding at pc_q; data goes to IF/ID or the hold buffer
// ST_HOLD  | decode stalled with a fetched word parked; no request issued
// ST_DRAIN | redirect arrived mid-request; finish the old handshake, then jump
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_d_i,
  input  logic        pcsrc_e_i,
  input  logic [31:0] pctarget_e_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pcplus4_d_o,
  output logic        valid_d_o,
  output logic        busy_o
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_INIT = CW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tgt_q, tgt_d;
  logic [31:0]   hold_instr_q, hold_instr_d;
  logic [31:0]   hold_pc_q, hold_pc_d;
  logic [31:0]   ifid_instr_q, ifid_instr_d;
  logic [31:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]   ifid_pcp4_q, ifid_pcp4_d;
  logic          valid_q, valid_d;

  logic        accept;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] hold_pc_plus4;

  // Masking with AND keeps every target bit referenced; the low two are always dropped.
  assign target        = pctarget_e_i & 32'hFFFF_FFFC;
  assign accept        = !(valid_q && stall_d_i);
  assign pc_plus4      = pc_q + 32'd4;
  assign hold_pc_plus4 = hold_pc_q + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= BOOT_INIT;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_pcp4_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    valid_d      = valid_q;
    imem_req_o   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          boot_cnt_d = boot_cnt_q - 1'b1;
        end
      end

      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (pcsrc_e_i) begin
          valid_d = 1'b0;
          if (imem_ack_i) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = ST_DRAIN;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_plus4;
          if (accept) begin
            ifid_instr_d = imem_rdata_i;
            ifid_pc_d    = pc_q;
            ifid_pcp4_d  = pc_plus4;
            valid_d      = 1'b1;
          end else begin
            hold_instr_d = imem_rdata_i;
            hold_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (pcsrc_e_i) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = ST_FETCH;
        end else if (accept) begin
          ifid_instr_d = hold_instr_q;
          ifid_pc_d    = hold_pc_q;
          ifid_pcp4_d  = hold_pc_plus4;
          valid_d      = 1'b1;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        // The old request stays up so the memory handshake is never abandoned.
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          pc_d    = pcsrc_e_i ? target : tgt_q;
          state_d = ST_FETCH;
        end else if (pcsrc_e_i) begin
          tgt_d = target;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_addr_o = imem_req_o ? pc_q : 32'h0;
  assign instr_d_o   = ifid_instr_q;
  assign pc_d_o      = ifid_pc_q;
  assign pcplus4_d_o = ifid_pcp4_q;
  assign valid_d_o   = valid_q;
  assign busy_o      = (state_q == ST_BOOT) || (state_q == ST_DRAIN);

endmodule
